// File: rtl/rcu_stream_bridge.sv
// Byte-lane bridge between the bus-side data registers and the byte-wide core port.
// HWRITE=1 unpacks a bus word into core bytes; HWRITE=0 packs core bytes into a bus word.
module rcu_stream_bridge #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned LANES     = BUS_WIDTH / 8,
    parameter logic [7:0]  EOT_CODE  = 8'hFF,
    parameter int unsigned CW        = $clog2(LANES + 1)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 HWRITE,
    input  logic                 bus_valid,
    output logic                 bus_ready,
    input  logic [BUS_WIDTH-1:0] data_out,
    input  logic [CW-1:0]        bus_nbytes,
    output logic [7:0]           data_outto_c,
    output logic                 c_valid,
    input  logic                 c_ready,
    input  logic [7:0]           data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [BUS_WIDTH-1:0] data_into_rcu,
    output logic [CW-1:0]        word_count,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 eot,
    input  logic                 clear_eot
);
    typedef enum logic [2:0] {StIdle, StUnpack, StPack, StWordOut, StEotHold} state_e;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]        idx_q, idx_d;      // unpack lane index, or pack byte count
    logic [CW-1:0]        count_q, count_d;  // bytes to unpack
    logic                 pending_eot_q, pending_eot_d;

    logic [7:0]           cur_byte;
    logic [BUS_WIDTH-1:0] word_ins;
    logic [CW-1:0]        eff_count;
    logic [CW-1:0]        cnt_next;
    logic                 in_acc;
    logic                 pack_close;

    // Lane select for the core byte and lane insert for the packer share the index register.
    always_comb begin
        cur_byte = 8'h00;
        word_ins = word_q;
        for (int i = 0; i < int'(LANES); i++) begin
            if (idx_q == CW'(i)) begin
                cur_byte             = word_q[i*8 +: 8];
                word_ins[i*8 +: 8]   = data_in;
            end
        end
    end

    assign eff_count  = (bus_nbytes == '0 || bus_nbytes > CW'(LANES)) ? CW'(LANES) : bus_nbytes;
    assign in_acc     = (state_q == StPack) && in_valid;
    assign cnt_next   = idx_q + CW'(in_acc);
    assign pack_close = (cnt_next == CW'(LANES)) || (in_acc && data_in == EOT_CODE) ||
                        (flush && cnt_next != '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (HWRITE && bus_valid) begin
                    state_d = StUnpack;
                end else if (!HWRITE && in_valid) begin
                    state_d = StPack;
                end
            end
            StUnpack: begin
                if (c_ready) begin
                    if (cur_byte == EOT_CODE) begin
                        state_d = StEotHold;
                    end else if (idx_q == count_q - 1'b1) begin
                        state_d = StIdle;
                    end
                end
            end
            StPack: begin
                if (pack_close) begin
                    state_d = StWordOut;
                end
            end
            StWordOut: begin
                if (word_ready) begin
                    state_d = pending_eot_q ? StEotHold : StIdle;
                end
            end
            StEotHold: begin
                if (clear_eot) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_ready     = 1'b0;
        data_outto_c  = 8'h00;
        c_valid       = 1'b0;
        in_ready      = 1'b0;
        data_into_rcu = '0;
        word_count    = '0;
        word_valid    = 1'b0;
        eot           = 1'b0;
        unique case (state_q)
            StIdle:    bus_ready = HWRITE && n_rst;
            StUnpack: begin
                c_valid      = 1'b1;
                data_outto_c = cur_byte;
            end
            StPack:    in_ready = 1'b1;
            StWordOut: begin
                word_valid    = 1'b1;
                data_into_rcu = word_q;
                word_count    = idx_q;
            end
            StEotHold: begin
                eot          = 1'b1;
                data_outto_c = EOT_CODE;
            end
            default: ;
        endcase
    end

    always_comb begin
        word_d        = word_q;
        idx_d         = idx_q;
        count_d       = count_q;
        pending_eot_d = pending_eot_q;
        unique case (state_q)
            StIdle: begin
                if (HWRITE && bus_valid) begin
                    word_d  = data_out;
                    idx_d   = '0;
                    count_d = eff_count;
                end
            end
            StUnpack: begin
                if (c_ready) begin
                    if (state_d == StUnpack) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        word_d  = '0;
                        idx_d   = '0;
                        count_d = '0;
                    end
                end
            end
            StPack: begin
                if (in_acc) begin
                    word_d = word_ins;
                    idx_d  = cnt_next;
                    if (data_in == EOT_CODE) begin
                        pending_eot_d = 1'b1;
                    end
                end
            end
            StWordOut: begin
                if (word_ready) begin
                    word_d        = '0;
                    idx_d         = '0;
                    pending_eot_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_q        <= '0;
            idx_q         <= '0;
            count_q       <= '0;
            pending_eot_q <= 1'b0;
        end else begin
            word_q        <= word_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            pending_eot_q <= pending_eot_d;
        end
    end

endmodule

// File: tb/tb_rcu_stream_bridge.sv
// Randomized self-checking bench for rcu_stream_bridge against a transaction-level byte model.
module tb_rcu_stream_bridge;
    localparam int unsigned BW  = 32;
    localparam int unsigned LN  = BW / 8;
    localparam int unsigned CWL = $clog2(LN + 1);
    localparam logic [7:0]  EOT = 8'hFF;

    logic           tb_clk = 1'b0;
    logic           n_rst;
    logic           HWRITE;
    logic           bus_valid;
    logic           bus_ready;
    logic [BW-1:0]  data_out;
    logic [CWL-1:0] bus_nbytes;
    logic [7:0]     data_outto_c;
    logic           c_valid;
    logic           c_ready;
    logic [7:0]     data_in;
    logic           in_valid;
    logic           in_ready;
    logic           flush;
    logic [BW-1:0]  data_into_rcu;
    logic [CWL-1:0] word_count;
    logic           word_valid;
    logic           word_ready;
    logic           eot;
    logic           clear_eot;

    int checks = 0;
    int errors = 0;

    always #5 tb_clk = ~tb_clk;

    rcu_stream_bridge #(
        .BUS_WIDTH(BW),
        .EOT_CODE (EOT)
    ) dut (
        .clk          (tb_clk),
        .n_rst        (n_rst),
        .HWRITE       (HWRITE),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .data_out     (data_out),
        .bus_nbytes   (bus_nbytes),
        .data_outto_c (data_outto_c),
        .c_valid      (c_valid),
        .c_ready      (c_ready),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .data_into_rcu(data_into_rcu),
        .word_count   (word_count),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .eot          (eot),
        .clear_eot    (clear_eot)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        HWRITE     = 1'b0;
        bus_valid  = 1'b0;
        data_out   = '0;
        bus_nbytes = '0;
        c_ready    = 1'b0;
        data_in    = 8'h00;
        in_valid   = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        clear_eot  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bus_ready"}, 32'(bus_ready), 0);
        check_eq({tag, "_c_valid"}, 32'(c_valid), 0);
        check_eq({tag, "_data_outto_c"}, 32'(data_outto_c), 0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 0);
        check_eq({tag, "_word_valid"}, 32'(word_valid), 0);
        check_eq({tag, "_data_into_rcu"}, data_into_rcu, 0);
        check_eq({tag, "_word_count"}, 32'(word_count), 0);
        check_eq({tag, "_eot"}, 32'(eot), 0);
    endtask

    // Sits in end-of-transfer, pokes every input, then clears.
    task automatic eot_hold_clear();
        int hold;
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) begin
            HWRITE     = 1'b1;
            bus_valid  = 1'b1;
            data_out   = 32'hFFFFFF12;
            in_valid   = 1'b1;
            data_in    = 8'($urandom);
            c_ready    = 1'b1;
            word_ready = 1'b1;
            flush      = 1'b1;
            #1;
            check_eq("hold_eot", 32'(eot), 1);
            check_eq("hold_data_outto_c", 32'(data_outto_c), 32'(EOT));
            check_eq("hold_bus_ready", 32'(bus_ready), 0);
            check_eq("hold_c_valid", 32'(c_valid), 0);
            check_eq("hold_in_ready", 32'(in_ready), 0);
            check_eq("hold_word_valid", 32'(word_valid), 0);
            @(negedge tb_clk);
        end
        idle_inputs();
        clear_eot = 1'b1;
        @(negedge tb_clk);
        clear_eot = 1'b0;
        check_eq("clear_eot", 32'(eot), 0);
        check_eq("clear_data_outto_c", 32'(data_outto_c), 0);
    endtask

    task automatic do_unpack(input logic [31:0] w, input logic [CWL-1:0] n, input bit stall);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int         eff;
        int         cyc;
        bit         exp_eot;
        bit         was_stalled;
        logic [7:0] held;
        logic [7:0] b;
        eff     = (n == 0 || n > LN) ? int'(LN) : int'(n);
        exp_eot = 1'b0;
        for (int i = 0; i < eff && !exp_eot; i++) begin
            b = w[i*8 +: 8];
            exp_q.push_back(b);
            if (b == EOT) exp_eot = 1'b1;
        end

        @(negedge tb_clk);
        HWRITE     = 1'b1;
        bus_valid  = 1'b1;
        data_out   = w;
        bus_nbytes = n;
        #1 check_eq("unpack_bus_ready", 32'(bus_ready), 1);
        @(negedge tb_clk);
        bus_valid  = 1'b0;
        data_out   = $urandom;
        bus_nbytes = CWL'($urandom);
        HWRITE     = 1'($urandom);
        check_eq("unpack_first_c_valid", 32'(c_valid), 1);
        was_stalled = 1'b0;
        held        = 8'h00;
        cyc         = 0;
        while (got_q.size() < exp_q.size() && cyc < 200) begin
            check_eq("unpack_c_valid", 32'(c_valid), 1);
            if (was_stalled) check_eq("unpack_hold_byte", 32'(data_outto_c), 32'(held));
            c_ready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            clear_eot = 1'($urandom_range(0, 1));
            if (c_ready) got_q.push_back(data_outto_c);
            was_stalled = !c_ready;
            held        = data_outto_c;
            cyc++;
            @(negedge tb_clk);
        end
        c_ready   = 1'($urandom_range(0, 1));
        clear_eot = 1'b0;
        HWRITE    = 1'b1;
        check_eq("unpack_timeout", 32'(cyc < 200), 1);
        if (!stall) check_eq("unpack_throughput", 32'(cyc), 32'(exp_q.size()));
        check_eq("unpack_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq("unpack_byte", 32'(got_q[i]), 32'(exp_q[i]));
        end
        #1;
        check_eq("unpack_end_c_valid", 32'(c_valid), 0);
        check_eq("unpack_end_eot", 32'(eot), 32'(exp_eot));
        check_eq("unpack_end_data", 32'(data_outto_c), exp_eot ? 32'(EOT) : 0);
        check_eq("unpack_end_bus_ready", 32'(bus_ready), 32'(!exp_eot));
        if (exp_eot) eot_hold_clear();
        else idle_inputs();
    endtask

    task automatic do_pack(input logic [31:0] src, input int len_req, input bit flush_last,
                           input int hold);
        logic [7:0]  bytes[$];
        logic [7:0]  b;
        logic [31:0] exp_w;
        int          exp_cnt;
        int          sent;
        int          cyc;
        int          gap;
        bit          exp_eot;
        bit          need_flush;
        for (int i = 0; i < len_req; i++) begin
            b = src[i*8 +: 8];
            bytes.push_back(b);
            if (b == EOT) break;
        end
        exp_cnt = bytes.size();
        exp_w   = '0;
        for (int i = 0; i < exp_cnt; i++) exp_w[i*8 +: 8] = bytes[i];
        exp_eot    = (bytes[exp_cnt-1] == EOT);
        need_flush = !exp_eot && exp_cnt < int'(LN);

        @(negedge tb_clk);
        HWRITE   = 1'b0;
        in_valid = 1'b1;
        data_in  = bytes[0];
        #1 check_eq("pack_idle_in_ready", 32'(in_ready), 0);
        @(negedge tb_clk);
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            flush    = 1'($urandom);
            check_eq("pack_empty_in_ready", 32'(in_ready), 1);
            @(negedge tb_clk);
        end
        sent = 0;
        cyc  = 0;
        while (sent < exp_cnt && cyc < 100) begin
            check_eq("pack_in_ready", 32'(in_ready), 1);
            if ($urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                data_in  = bytes[sent];
                sent++;
                flush    = (sent == exp_cnt) && need_flush && flush_last;
            end else begin
                in_valid = 1'b0;
                data_in  = 8'($urandom);
                flush    = 1'b0;
            end
            cyc++;
            @(negedge tb_clk);
        end
        check_eq("pack_timeout", 32'(cyc < 100), 1);
        if (need_flush && !flush_last) begin
            in_valid = 1'b0;
            flush    = 1'b1;
            @(negedge tb_clk);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            word_ready = (i == hold);
            in_valid   = 1'($urandom);
            data_in    = 8'($urandom);
            #1;
            check_eq("pack_word_valid", 32'(word_valid), 1);
            check_eq("pack_word", data_into_rcu, exp_w);
            check_eq("pack_word_count", 32'(word_count), 32'(exp_cnt));
            check_eq("pack_wo_in_ready", 32'(in_ready), 0);
            @(negedge tb_clk);
        end
        word_ready = 1'b0;
        in_valid   = 1'b0;
        #1;
        check_eq("pack_end_word_valid", 32'(word_valid), 0);
        check_eq("pack_end_word", data_into_rcu, 0);
        check_eq("pack_end_word_count", 32'(word_count), 0);
        check_eq("pack_end_in_ready", 32'(in_ready), 0);
        check_eq("pack_end_eot", 32'(eot), 32'(exp_eot));
        if (exp_eot) eot_hold_clear();
        else idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          lane;
        idle_inputs();
        n_rst     = 1'b0;
        HWRITE    = 1'b1;
        bus_valid = 1'b1;
        data_out  = 32'hFFFFFFFF;
        repeat (2) @(negedge tb_clk);
        check_all_zero("reset");
        idle_inputs();
        n_rst = 1'b1;

        do_unpack(32'h44332211, 3'd0, 1'b0);
        do_unpack(32'h44332211, 3'd0, 1'b1);
        do_unpack(32'h12FF3433, 3'd4, 1'b0);
        do_pack(32'h00003412, 2, 1'b0, 3);
        do_pack(32'h0000FF21, 2, 1'b0, 1);
        do_unpack(32'h000000AB, 3'd1, 1'b0);
        do_unpack(32'h87654321, 3'd6, 1'b1);
        do_pack(32'h44332211, 4, 1'b0, 0);

        // Asynchronous reset in the middle of an unpack.
        @(negedge tb_clk);
        HWRITE     = 1'b1;
        bus_valid  = 1'b1;
        data_out   = 32'hA5A5A5A5;
        bus_nbytes = 3'd4;
        @(negedge tb_clk);
        bus_valid = 1'b0;
        c_ready   = 1'b0;
        check_eq("pre_reset_c_valid", 32'(c_valid), 1);
        #2 n_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge tb_clk);
        idle_inputs();
        n_rst = 1'b1;

        for (int t = 0; t < 40; t++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                lane = $urandom_range(0, int'(LN) - 1);
                w[lane*8 +: 8] = EOT;
            end
            if ($urandom_range(0, 1) == 0) begin
                do_unpack(w, CWL'($urandom_range(0, 7)), 1'($urandom));
            end else begin
                do_pack(w, $urandom_range(1, int'(LN)), 1'($urandom), $urandom_range(0, 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcu_stream_bridge.md
Name: rcu_stream_bridge

Overview:
- Parametrised successor to the single-byte RCU data path. Sits between the 32-bit AHB-side data registers and the byte-wide core interface.
- Bus→core (HWRITE=1): unpacks one bus word into 1..LANES bytes, LSB lane first, under a valid/ready handshake.
- Core→bus (HWRITE=0): packs incoming bytes into a zero-padded bus word.
- A configurable end-of-transfer byte sets a sticky eot that freezes the path until it is explicitly cleared.

Parameters:
BUS_WIDTH, 32, bus word width; must be a multiple of 8.
LANES, BUS_WIDTH/8, byte lanes per word (derived; not overridden).
EOT_CODE, 8'hFF, byte value that marks end of transfer.
CW, $clog2(LANES+1), width of byte-count fields (derived).

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
HWRITE  in  1  direction select, sampled only in IDLE; 1 = bus→core, 0 = core→bus.
bus_valid  in  1  data_out/bus_nbytes valid.
bus_ready  out  1  bridge accepts the bus word this cycle.
data_out  in  BUS_WIDTH  bus write word, lane 0 = bits [7:0].
bus_nbytes  in  CW  number of bytes to unpack; 0 or >LANES is treated as LANES.
data_outto_c  out  8  byte to core.
c_valid  out  1  data_outto_c valid.
c_ready  in  1  core accepts the byte.
data_in  in  8  byte from core.
in_valid  in  1  data_in valid.
in_ready  out  1  bridge accepts data_in.
flush  in  1  close a partial packed word.
data_into_rcu  out  BUS_WIDTH  packed word to bus, zero-padded.
word_count  out  CW  valid bytes in data_into_rcu.
word_valid  out  1  packed word valid.
word_ready  in  1  bus accepts the word.
eot  out  1  sticky end-of-transfer flag.
clear_eot  in  1  clears eot; return to IDLE.

Behaviour:
- Reset (async, n_rst=0): state IDLE. All outputs 0. The word register, lane index and byte count are cleared. Reset mid-transfer discards all partial data.
- FSM states: IDLE, UNPACK, PACK, WORD_OUT, EOT_HOLD.

IDLE:
- bus_ready = HWRITE & ~eot (combinational).
- HWRITE=1 & bus_valid: capture data_out and the effective byte count. Lane index = 0. Go to UNPACK.
- HWRITE=0 & in_valid: go to PACK. The byte is not consumed this cycle; in_ready=0 in IDLE.

UNPACK:
- data_outto_c = captured lane[idx]; c_valid=1.
- Byte/valid are stable until c_valid & c_ready.
- On a handshake with byte == EOT_CODE: set eot and go to EOT_HOLD. Remaining lanes are discarded.
- Otherwise, if idx == count-1: go to IDLE, with c_valid=0 and data_outto_c=0 from the next cycle. Else idx+1.
- Throughput: 1 byte/cycle when c_ready is held high. Latency from bus handshake to first c_valid is 1 cycle.

PACK:
- in_ready=1.
- Each in_valid & in_ready writes data_in into lane[cnt] and increments cnt.
- Close the word (go to WORD_OUT) on the first of:
  - cnt reaches LANES;
  - the accepted byte == EOT_CODE; it is stored, and the pending_eot flag is set;
  - flush=1 with cnt>=1, where a byte accepted in the same cycle is included.
- flush with cnt=0 and no byte: ignored.

WORD_OUT:
- word_valid=1; data_into_rcu = lanes, unused upper lanes 0; word_count = cnt; in_ready=0.
- Held stable until word_ready.
- On handshake: clear the word register and cnt. Then:
  - if pending_eot: eot=1, go to EOT_HOLD;
  - else go to IDLE.
- data_into_rcu and word_count are 0 whenever word_valid=0.

EOT_HOLD:
- eot=1, data_outto_c=EOT_CODE, c_valid=0, bus_ready=0, in_ready=0, word_valid=0.
- All bus/core inputs are ignored.
- clear_eot=1 → IDLE next cycle; eot=0 and data_outto_c=0.
- clear_eot in any other state has no effect.

General:
- No combinational path from c_ready or word_ready to the data outputs. Outputs are registered or state-decoded.

Test Plan:
1. Reset: drive data_out=32'hFFFFFFFF, HWRITE=1, bus_valid=1, n_rst=0 for 2 cycles → all outputs 0, eot=0, bus_ready=0.
2. Unpack full word: HWRITE=1, data_out=32'h44332211, bus_nbytes=0, c_ready=1 → c_valid for 4 consecutive cycles with bytes 11,22,33,44, then IDLE; eot=0. Repeat with c_ready toggling → byte held, no byte lost or duplicated.
3. Unpack with EOT: data_out=32'h12FF3433, bus_nbytes=4 → core sees 33,34,FF; eot=1 the cycle after the FF handshake; data_outto_c=FF. A following bus_valid with 32'hFFFFFF12 → bus_ready=0 and output stays FF.
4. Pack with flush: HWRITE=0, bytes 12,34 then flush=1 → word_valid with data_into_rcu=32'h00003412, word_count=2. Hold word_ready=0 for 3 cycles → word stable. word_ready=1 → IDLE.
5. Pack to EOT: bytes 21,FF → word 32'h0000FF21, count 2. eot=1 after the word handshake; in_ready=0 afterwards.
6. clear_eot from EOT_HOLD → eot=0 next cycle. A new unpack of 32'h000000AB with bus_nbytes=1 delivers AB. Assert n_rst mid-UNPACK → outputs 0 immediately (async).
